// File: rtl/branch_pkg.sv
// Shared types and helpers for the branch predictor: 2-bit counter states,
// saturating counter arithmetic and PC index/tag slicing.
package branch_pkg;

    typedef enum logic [1:0] {
        STRONG_NT = 2'b00,
        WEAK_NT   = 2'b01,
        WEAK_T    = 2'b10,
        STRONG_T  = 2'b11
    } ctr_e;

    localparam ctr_e CTR_RST = WEAK_NT;

    function automatic ctr_e sat_inc(ctr_e c);
        return (c == STRONG_T) ? STRONG_T : ctr_e'(c + 2'd1);
    endfunction

    function automatic ctr_e sat_dec(ctr_e c);
        return (c == STRONG_NT) ? STRONG_NT : ctr_e'(c - 2'd1);
    endfunction

    // PCs are word aligned, so bits [1:0] never take part in index or tag.
    function automatic logic [31:0] pc_idx(logic [63:0] pc, int unsigned idxw);
        return 32'((pc >> 2) & ((64'd1 << idxw) - 64'd1));
    endfunction

    function automatic logic [31:0] pc_tag(logic [63:0] pc, int unsigned idxw,
                                           int unsigned tagbits);
        return 32'((pc >> (idxw + 2)) & ((64'd1 << tagbits) - 64'd1));
    endfunction

endpackage

// File: rtl/bht_counter_array.sv
// Table of 2-bit saturating direction counters: one combinational read port
// for fetch and one read-modify-write port for resolved branches.
module bht_counter_array
    import branch_pkg::*;
#(
    parameter int Entries = 64,
    localparam int IdxW   = $clog2(Entries)
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic [IdxW-1:0] rd_idx_i,
    output logic [1:0]      rd_ctr_o,
    input  logic            wr_en_i,
    input  logic [IdxW-1:0] wr_idx_i,
    input  logic            wr_taken_i
);

    ctr_e ctr_q [Entries];
    ctr_e ctr_d;

    // No tag check: aliasing branches deliberately share a counter.
    always_comb begin
        ctr_d = wr_taken_i ? sat_inc(ctr_q[wr_idx_i]) : sat_dec(ctr_q[wr_idx_i]);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < Entries; i++) ctr_q[i] <= CTR_RST;
        end else if (wr_en_i) begin
            ctr_q[wr_idx_i] <= ctr_d;
        end
    end

    assign rd_ctr_o = ctr_q[rd_idx_i];

endmodule

// File: rtl/branch_target_predictor.sv
// Direction counters plus tagged BTB for fetch, with execute-stage
// misprediction detection, redirect PC and a saturating mispredict counter.
module branch_target_predictor
    import branch_pkg::*;
#(
    parameter int WordSize = 32,
    parameter int Entries  = 64,
    parameter int TagBits  = 8,
    parameter int CountW   = 16
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic [WordSize-1:0] fetch_pc,
    output logic                pred_taken,
    output logic [WordSize-1:0] pred_pc,
    input  logic                upd_valid,
    input  logic [WordSize-1:0] upd_pc,
    input  logic                upd_taken,
    input  logic [WordSize-1:0] upd_target,
    input  logic                upd_pred_taken,
    input  logic [WordSize-1:0] upd_pred_pc,
    output logic                flush,
    output logic [WordSize-1:0] npc_corr,
    output logic [CountW-1:0]   mispredict_count
);

    localparam int IdxW = $clog2(Entries);

    logic [IdxW-1:0]     f_idx, u_idx;
    logic [TagBits-1:0]  f_tag, u_tag;
    logic [1:0]          f_ctr;
    logic                f_hit;

    logic [Entries-1:0]  valid_q;
    logic [TagBits-1:0]  tag_q [Entries];
    logic [WordSize-1:0] tgt_q [Entries];
    logic [CountW-1:0]   count_q, count_d;

    assign f_idx = IdxW'(pc_idx(64'(fetch_pc), IdxW));
    assign f_tag = TagBits'(pc_tag(64'(fetch_pc), IdxW, TagBits));
    assign u_idx = IdxW'(pc_idx(64'(upd_pc), IdxW));
    assign u_tag = TagBits'(pc_tag(64'(upd_pc), IdxW, TagBits));

    bht_counter_array #(.Entries(Entries)) u_bht (
        .clk        (clk),
        .rstn       (rstn),
        .rd_idx_i   (f_idx),
        .rd_ctr_o   (f_ctr),
        .wr_en_i    (upd_valid),
        .wr_idx_i   (u_idx),
        .wr_taken_i (upd_taken)
    );

    // Fetch path reads flops only, so same-cycle updates are not forwarded.
    assign f_hit      = valid_q[f_idx] && (tag_q[f_idx] == f_tag);
    assign pred_taken = f_hit && f_ctr[1];
    assign pred_pc    = pred_taken ? tgt_q[f_idx] : fetch_pc + WordSize'(4);

    assign flush    = rstn && upd_valid &&
                      ((upd_taken != upd_pred_taken) ||
                       (upd_taken && (upd_pred_pc != upd_target)));
    assign npc_corr = upd_taken ? upd_target : upd_pc + WordSize'(4);

    always_comb begin
        count_d = count_q;
        if (flush && (count_q != '1)) count_d = count_q + CountW'(1);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            valid_q <= '0;
            count_q <= '0;
        end else begin
            if (upd_valid && upd_taken) valid_q[u_idx] <= 1'b1;
            count_q <= count_d;
        end
    end

    // Tag and target are qualified by valid, so they need no reset.
    always_ff @(posedge clk) begin
        if (upd_valid && upd_taken) begin
            tag_q[u_idx] <= u_tag;
            tgt_q[u_idx] <= upd_target;
        end
    end

    assign mispredict_count = count_q;

endmodule

// File: tb/tb_branch_target_predictor.sv
// Scoreboard bench: stimulus pushes model expectations, a negedge monitor
// pops and compares against the DUT.
module tb_branch_target_predictor;

    localparam int W = 32, E = 64, TB = 8, CW = 4;

    logic          clk = 1'b0, rstn = 1'b0;
    logic [W-1:0]  fetch_pc = '0, upd_pc = '0, upd_target = '0, upd_pred_pc = '0;
    logic          upd_valid = 1'b0, upd_taken = 1'b0, upd_pred_taken = 1'b0;
    logic          pred_taken, flush;
    logic [W-1:0]  pred_pc, npc_corr;
    logic [CW-1:0] mispredict_count;

    branch_target_predictor #(.WordSize(W), .Entries(E), .TagBits(TB), .CountW(CW)) dut (
        .clk(clk), .rstn(rstn), .fetch_pc(fetch_pc), .pred_taken(pred_taken),
        .pred_pc(pred_pc), .upd_valid(upd_valid), .upd_pc(upd_pc),
        .upd_taken(upd_taken), .upd_target(upd_target),
        .upd_pred_taken(upd_pred_taken), .upd_pred_pc(upd_pred_pc),
        .flush(flush), .npc_corr(npc_corr), .mispredict_count(mispredict_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic         pt;
        logic [W-1:0] ppc;
        logic         fl;
        logic [W-1:0] npc;
        int           cnt;
    } exp_t;

    exp_t q[$];
    int total = 0, bad = 0;

    // Reference model: direction state 0..3, BTB entry, statistics count.
    int           m_ctr [E];
    bit           m_v   [E];
    int unsigned  m_tag [E];
    logic [W-1:0] m_tgt [E];
    int           m_cnt;

    function automatic int midx(logic [W-1:0] pc); return int'((pc >> 2) % E); endfunction
    function automatic int unsigned mtag(logic [W-1:0] pc); return (pc >> 8) % 256; endfunction

    function automatic void m_reset();
        for (int i = 0; i < E; i++) begin m_ctr[i] = 1; m_v[i] = 0; end
        m_cnt = 0;
    endfunction

    function automatic void m_pred(input logic [W-1:0] pc, output logic pt, output logic [W-1:0] ppc);
        int i = midx(pc);
        pt  = m_v[i] && (m_tag[i] == mtag(pc)) && (m_ctr[i] >= 2);
        ppc = pt ? m_tgt[i] : pc + 4;
    endfunction

    task automatic chk(string nm, logic [W-1:0] act, logic [W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (q.size() > 0) begin
            e = q.pop_front();
            chk("pred_taken", W'(pred_taken), W'(e.pt));
            chk("pred_pc", pred_pc, e.ppc);
            chk("flush", W'(flush), W'(e.fl));
            if (e.fl) chk("npc_corr", npc_corr, e.npc);
            chk("count", W'(mispredict_count), W'(e.cnt));
        end
    end

    task automatic step(logic [W-1:0] fpc, logic uv, logic [W-1:0] upc, logic ut,
                        logic [W-1:0] utgt, logic upt, logic [W-1:0] uppc);
        exp_t e;
        int i;
        @(posedge clk); #1;
        fetch_pc = fpc; upd_valid = uv; upd_pc = upc; upd_taken = ut;
        upd_target = utgt; upd_pred_taken = upt; upd_pred_pc = uppc;
        m_pred(fpc, e.pt, e.ppc);
        e.fl  = uv && ((ut != upt) || (ut && uppc != utgt));
        e.npc = ut ? utgt : upc + 4;
        e.cnt = m_cnt;
        q.push_back(e);
        if (uv) begin
            i = midx(upc);
            m_ctr[i] = ut ? ((m_ctr[i] < 3) ? m_ctr[i] + 1 : 3) : ((m_ctr[i] > 0) ? m_ctr[i] - 1 : 0);
            if (ut) begin m_v[i] = 1; m_tag[i] = mtag(upc); m_tgt[i] = utgt; end
        end
        if (e.fl && m_cnt < (1 << CW) - 1) m_cnt++;
    endtask

    task automatic fetch(logic [W-1:0] fpc);
        step(fpc, 0, 0, 0, 0, 0, 0);
    endtask

    // Resolve a branch with the prediction the model would have made for it.
    task automatic resolve(logic [W-1:0] fpc, logic [W-1:0] upc, logic ut, logic [W-1:0] utgt);
        logic pt; logic [W-1:0] ppc;
        m_pred(upc, pt, ppc);
        step(fpc, 1, upc, ut, utgt, pt, ppc);
    endtask

    function automatic logic [W-1:0] rpc();
        logic [W-1:0] p;
        p = (W'($urandom_range(0, 2)) << 8) | (W'($urandom_range(0, 3)) << 2);
        if ($urandom_range(0, 3) == 0) p = p | ($urandom & 32'hFFFF_0000);
        return p;
    endfunction

    initial begin
        logic pt; logic [W-1:0] ppc, p, f;
        m_reset();
        rstn = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk) rstn = 1'b1;

        // Reset state
        fetch(32'h100);
        // First taken branch is a mispredict; then it hits
        step(32'h100, 1, 32'h100, 1, 32'h200, 0, 32'h104);
        #2 chk("first_flush", W'(flush), 1); chk("first_npc", npc_corr, 32'h200);
        fetch(32'h100);
        #2 chk("first_hit_pc", pred_pc, 32'h200);
        // Alias with different tag must miss
        fetch(32'h4100);
        #2 chk("alias_pc", pred_pc, 32'h4104);
        // Hysteresis
        repeat (3) resolve(32'h100, 32'h100, 1, 32'h200);
        step(32'h100, 1, 32'h100, 0, 32'h0, 1, 32'h200);
        #2 chk("hyst_npc", npc_corr, 32'h104);
        fetch(32'h100);
        #2 chk("hyst_still_taken", W'(pred_taken), 1);
        resolve(32'h100, 32'h100, 0, 32'h0);
        fetch(32'h100);
        #2 chk("hyst_now_nt", W'(pred_taken), 0);
        // Wrong target: same-cycle fetch sees old target
        resolve(32'h100, 32'h100, 1, 32'h180);
        step(32'h100, 1, 32'h100, 1, 32'h200, 1, 32'h300);
        #2 chk("wt_old_target", pred_pc, 32'h180);
        fetch(32'h100);
        #2 chk("wt_new_target", pred_pc, 32'h200);
        // Fall-through wraps modulo 2^W
        fetch(32'hFFFF_FFFC);

        // Counter saturation, then asynchronous reset mid-update
        for (int k = 0; k < 20; k++) step(32'h100, 1, 32'h180, 1, 32'h300, 0, 32'h184);
        fetch(32'h180);
        #2 chk("count_sat", W'(mispredict_count), 32'hF);
        @(posedge clk); #1;
        fetch_pc = 32'h180; upd_valid = 1; upd_pc = 32'h180; upd_taken = 1;
        upd_target = 32'h400; upd_pred_taken = 0;
        #1 chk("pre_rst_flush", W'(flush), 1);
        rstn = 1'b0; m_reset();
        #1 chk("rst_flush", W'(flush), 0);
        chk("rst_count", W'(mispredict_count), 0);
        chk("rst_pred_taken", W'(pred_taken), 0);
        chk("rst_pred_pc", pred_pc, 32'h184);
        @(negedge clk); upd_valid = 0;
        @(negedge clk) rstn = 1'b1;
        // First edge after reset release is honoured
        step(32'h180, 1, 32'h180, 1, 32'h400, 0, 32'h184);
        fetch(32'h180);

        for (int k = 0; k < 400; k++) begin
            p = rpc(); f = ($urandom_range(0, 3) == 0) ? p : rpc();
            if ($urandom_range(0, 3) == 0) fetch(f);
            else if ($urandom_range(0, 9) < 7) resolve(f, p, 1'($urandom), $urandom & 32'hFFFF_FFFC);
            else begin
                m_pred(p, pt, ppc);
                step(f, 1, p, 1'($urandom), ($urandom_range(0, 1) ? ppc : ($urandom & 32'hFFFF_FFFC)),
                     1'($urandom), ($urandom_range(0, 1) ? ppc : ($urandom & 32'hFFFF_FFFC)));
            end
        end
        @(posedge clk); #1 upd_valid = 0;
        repeat (2) @(negedge clk);
        chk("queue_drained", W'(q.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
